// File: rtl/control_pipe_if.sv
// Decoder-to-pipeline control bundle: ID-stage inputs
// and the registered per-stage control outputs.
interface control_pipe_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      ctrl_i;
  logic [4:0]       wr_reg_i;
  logic             hazard_i;
  logic             flush_i;
  logic             freeze_i;
  logic             ex_regdst_o;
  logic [1:0]       ex_aluop_o;
  logic             ex_alusrc_o;
  logic             ex_memread_o;
  logic [4:0]       ex_wr_reg_o;
  logic             mem_memread_o;
  logic             mem_memwrite_o;
  logic             mem_regwrite_o;
  logic [4:0]       mem_wr_reg_o;
  logic             wb_regwrite_o;
  logic             wb_memtoreg_o;
  logic [4:0]       wb_wr_reg_o;
  logic [CNT_W-1:0] bubble_cnt_o;
  logic             illegal_o;

  modport master (
    output ctrl_i, wr_reg_i, hazard_i,
    output flush_i, freeze_i,
    input  ex_regdst_o, ex_aluop_o,
    input  ex_alusrc_o, ex_memread_o,
    input  ex_wr_reg_o,
    input  mem_memread_o, mem_memwrite_o,
    input  mem_regwrite_o, mem_wr_reg_o,
    input  wb_regwrite_o, wb_memtoreg_o,
    input  wb_wr_reg_o,
    input  bubble_cnt_o, illegal_o
  );

  modport slave (
    input  ctrl_i, wr_reg_i, hazard_i,
    input  flush_i, freeze_i,
    output ex_regdst_o, ex_aluop_o,
    output ex_alusrc_o, ex_memread_o,
    output ex_wr_reg_o,
    output mem_memread_o, mem_memwrite_o,
    output mem_regwrite_o, mem_wr_reg_o,
    output wb_regwrite_o, wb_memtoreg_o,
    output wb_wr_reg_o,
    output bubble_cnt_o, illegal_o
  );
endinterface

// File: rtl/control_pipe.sv
// Stages decoder control bits and rd through ID/EX,
// EX/MEM and MEM/WB with bubble, flush and freeze.
module control_pipe #(
  parameter int CNT_W = 16
) (
  input logic          clk_i,
  input logic          rst_i,
  control_pipe_if.slave bus
);
  typedef struct packed {
    logic [7:0] ctrl;
    logic [4:0] rd;
  } stage_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  stage_t           id_ex;
  stage_t           ex_mem;
  stage_t           mem_wb;
  logic [CNT_W-1:0] cnt;
  logic             illegal;
  logic             bubble;
  logic             rsvd;

  assign bubble = bus.flush_i | bus.hazard_i;
  assign rsvd   = |bus.ctrl_i[31:10];

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      id_ex   <= '0;
      ex_mem  <= '0;
      mem_wb  <= '0;
      cnt     <= '0;
      illegal <= 1'b0;
    end else if (!bus.freeze_i) begin
      mem_wb <= ex_mem;
      ex_mem <= id_ex;
      if (bubble) begin
        id_ex <= '0;
        if (cnt != CNT_MAX)
          cnt <= cnt + 1'b1;
      end else begin
        id_ex.ctrl <= bus.ctrl_i[7:0];
        id_ex.rd   <= bus.wr_reg_i;
        if (rsvd)
          illegal <= 1'b1;
      end
    end
  end

  // ctrl bits: 0 RegWrite, 1 MemToReg, 2 MemWrite,
  // 3 MemRead, 4 RegDst, 6:5 ALUOp, 7 ALUSrc
  assign bus.ex_regdst_o    = id_ex.ctrl[4];
  assign bus.ex_aluop_o     = id_ex.ctrl[6:5];
  assign bus.ex_alusrc_o    = id_ex.ctrl[7];
  assign bus.ex_memread_o   = id_ex.ctrl[3];
  assign bus.ex_wr_reg_o    = id_ex.rd;
  assign bus.mem_memread_o  = ex_mem.ctrl[3];
  assign bus.mem_memwrite_o = ex_mem.ctrl[2];
  assign bus.mem_regwrite_o = ex_mem.ctrl[0];
  assign bus.mem_wr_reg_o   = ex_mem.rd;
  assign bus.wb_regwrite_o  = mem_wb.ctrl[0];
  assign bus.wb_memtoreg_o  = mem_wb.ctrl[1];
  assign bus.wb_wr_reg_o    = mem_wb.rd;
  assign bus.bubble_cnt_o   = cnt;
  assign bus.illegal_o      = illegal;
endmodule

// File: tb/tb_control_pipe.sv
// Directed bench for control_pipe: reset, flow,
// load-use, freeze+flush, saturation, illegal.
module tb_control_pipe;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;

  control_pipe_if #(.CNT_W(16)) bus ();
  control_pipe_if #(.CNT_W(4))  sbus ();

  control_pipe #(.CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus.slave)
  );
  control_pipe #(.CNT_W(4)) dut_sat (
    .clk_i(clk), .rst_i(rst), .bus(sbus.slave)
  );

  always #5 clk = ~clk;

  // {regdst, aluop, alusrc, memread, wr_reg}
  logic [9:0] ex_vec;
  // {memread, memwrite, regwrite, wr_reg}
  logic [7:0] mem_vec;
  // {regwrite, memtoreg, wr_reg}
  logic [6:0] wb_vec;
  assign ex_vec = {bus.ex_regdst_o, bus.ex_aluop_o,
                   bus.ex_alusrc_o, bus.ex_memread_o,
                   bus.ex_wr_reg_o};
  assign mem_vec = {bus.mem_memread_o,
                    bus.mem_memwrite_o,
                    bus.mem_regwrite_o,
                    bus.mem_wr_reg_o};
  assign wb_vec = {bus.wb_regwrite_o,
                   bus.wb_memtoreg_o,
                   bus.wb_wr_reg_o};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] c,
                       input logic [4:0] r,
                       input logic h, f, z);
    bus.ctrl_i   = c;
    bus.wr_reg_i = r;
    bus.hazard_i = h;
    bus.flush_i  = f;
    bus.freeze_i = z;
  endtask

  task automatic do_reset();
    drive(32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    sbus.ctrl_i = '0; sbus.wr_reg_i = '0;
    sbus.hazard_i = 0; sbus.flush_i = 0;
    sbus.freeze_i = 0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    drive(32'h0000_00AB, 5'd7, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    tick();
    total++;
    if ({ex_vec, mem_vec, wb_vec, bus.bubble_cnt_o,
         bus.illegal_o} !== 42'h0) begin
      bad++;
      $display("FAIL reset_outs got ex=%h mem=%h wb=%h cnt=%h ill=%b exp all 0",
               ex_vec, mem_vec, wb_vec,
               bus.bubble_cnt_o, bus.illegal_o);
    end
    rst = 1'b1;
    tick();
    total++;
    if ({bus.ex_alusrc_o, bus.ex_memread_o} !== 2'b11) begin
      bad++;
      $display("FAIL reset_release got alusrc=%b memread=%b exp 1 1",
               bus.ex_alusrc_o, bus.ex_memread_o);
    end
    total++;
    if (ex_vec !== {1'b0, 2'b01, 1'b1, 1'b1, 5'd7}) begin
      bad++;
      $display("FAIL reset_ex got %h exp %h",
               ex_vec, {1'b0, 2'b01, 1'b1, 1'b1, 5'd7});
    end
  endtask

  task automatic test_flow();
    do_reset();
    drive(32'h0000_0051, 5'd3, 1'b0, 1'b0, 1'b0);
    tick();
    total++;
    if (ex_vec !== {1'b1, 2'b10, 1'b0, 1'b0, 5'd3}) begin
      bad++;
      $display("FAIL flow_ex_r got %h exp %h",
               ex_vec, {1'b1, 2'b10, 1'b0, 1'b0, 5'd3});
    end
    drive(32'h0000_00AB, 5'd5, 1'b0, 1'b0, 1'b0);
    tick();
    total++;
    if (mem_vec !== {1'b0, 1'b0, 1'b1, 5'd3}) begin
      bad++;
      $display("FAIL flow_mem_r got %h exp %h",
               mem_vec, {1'b0, 1'b0, 1'b1, 5'd3});
    end
    drive(32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    total++;
    if (wb_vec !== {1'b1, 1'b0, 5'd3}) begin
      bad++;
      $display("FAIL flow_wb_r got %h exp %h",
               wb_vec, {1'b1, 1'b0, 5'd3});
    end
    total++;
    if (mem_vec !== {1'b1, 1'b0, 1'b1, 5'd5}) begin
      bad++;
      $display("FAIL flow_mem_lw got %h exp %h",
               mem_vec, {1'b1, 1'b0, 1'b1, 5'd5});
    end
    tick();
    total++;
    if (wb_vec !== {1'b1, 1'b1, 5'd5}) begin
      bad++;
      $display("FAIL flow_wb_lw got %h exp %h",
               wb_vec, {1'b1, 1'b1, 5'd5});
    end
    total++;
    if (ex_vec !== 10'h0 || bus.illegal_o !== 1'b0) begin
      bad++;
      $display("FAIL flow_nop got ex=%h ill=%b exp 0 0",
               ex_vec, bus.illegal_o);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(32'h0000_00AB, 5'd5, 1'b0, 1'b0, 1'b0);
    tick();
    drive(32'h0000_00AB, 5'd6, 1'b1, 1'b0, 1'b0);
    tick();
    total++;
    if (ex_vec !== 10'h0) begin
      bad++;
      $display("FAIL lu_ex_bubble got %h exp 0", ex_vec);
    end
    total++;
    if (bus.bubble_cnt_o !== 16'd1) begin
      bad++;
      $display("FAIL lu_cnt got %0d exp 1",
               bus.bubble_cnt_o);
    end
    total++;
    if (mem_vec !== {1'b1, 1'b0, 1'b1, 5'd5}) begin
      bad++;
      $display("FAIL lu_mem got %h exp %h",
               mem_vec, {1'b1, 1'b0, 1'b1, 5'd5});
    end
    drive(32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    total++;
    if (wb_vec !== 7'h0) begin
      bad++;
      $display("FAIL lu_wb_bubble got %h exp 0", wb_vec);
    end
  endtask

  task automatic test_freeze_flush();
    do_reset();
    drive(32'h0000_0051, 5'd3, 1'b0, 1'b0, 1'b0);
    tick();
    drive(32'h0000_00AB, 5'd5, 1'b0, 1'b0, 1'b0);
    tick();
    drive(32'h0000_0051, 5'd9, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (ex_vec !== {1'b0, 2'b01, 1'b1, 1'b1, 5'd5} ||
          mem_vec !== {1'b0, 1'b0, 1'b1, 5'd3} ||
          wb_vec !== 7'h0 ||
          bus.bubble_cnt_o !== 16'd0) begin
        bad++;
        $display("FAIL frz_hold%0d got ex=%h mem=%h wb=%h cnt=%0d exp ex=%h mem=%h wb=0 cnt=0",
                 i, ex_vec, mem_vec, wb_vec,
                 bus.bubble_cnt_o,
                 {1'b0, 2'b01, 1'b1, 1'b1, 5'd5},
                 {1'b0, 1'b0, 1'b1, 5'd3});
      end
    end
    bus.freeze_i = 1'b0;
    tick();
    total++;
    if (ex_vec !== 10'h0 ||
        mem_vec !== {1'b1, 1'b0, 1'b1, 5'd5} ||
        wb_vec !== {1'b1, 1'b0, 5'd3}) begin
      bad++;
      $display("FAIL frz_release got ex=%h mem=%h wb=%h",
               ex_vec, mem_vec, wb_vec);
    end
    total++;
    if (bus.bubble_cnt_o !== 16'd1) begin
      bad++;
      $display("FAIL frz_cnt got %0d exp 1",
               bus.bubble_cnt_o);
    end
    bus.flush_i  = 1'b1;
    bus.hazard_i = 1'b1;
    tick();
    total++;
    if (bus.bubble_cnt_o !== 16'd2) begin
      bad++;
      $display("FAIL both_once got %0d exp 2",
               bus.bubble_cnt_o);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    sbus.flush_i = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 14 || i == 15 || i == 20) begin
        total++;
        if (sbus.bubble_cnt_o !==
            ((i == 14) ? 4'hE : 4'hF)) begin
          bad++;
          $display("FAIL sat_%0d got %h exp %h",
                   i, sbus.bubble_cnt_o,
                   (i == 14) ? 4'hE : 4'hF);
        end
      end
    end
    sbus.flush_i = 1'b0;
  endtask

  task automatic test_illegal();
    do_reset();
    drive(32'h0000_0401, 5'd2, 1'b0, 1'b0, 1'b1);
    tick();
    total++;
    if (bus.illegal_o !== 1'b0) begin
      bad++;
      $display("FAIL ill_frozen got %b exp 0",
               bus.illegal_o);
    end
    drive(32'h0000_0401, 5'd2, 1'b1, 1'b0, 1'b0);
    tick();
    total++;
    if (bus.illegal_o !== 1'b0) begin
      bad++;
      $display("FAIL ill_bubble got %b exp 0",
               bus.illegal_o);
    end
    drive(32'h0000_0401, 5'd2, 1'b0, 1'b0, 1'b0);
    tick();
    total++;
    if (bus.illegal_o !== 1'b1) begin
      bad++;
      $display("FAIL ill_set got %b exp 1",
               bus.illegal_o);
    end
    drive(32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    total++;
    if (bus.illegal_o !== 1'b1 ||
        wb_vec !== {1'b1, 1'b0, 5'd2}) begin
      bad++;
      $display("FAIL ill_sticky got ill=%b wb=%h exp 1 %h",
               bus.illegal_o, wb_vec,
               {1'b1, 1'b0, 5'd2});
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    total++;
    if (bus.illegal_o !== 1'b0) begin
      bad++;
      $display("FAIL ill_clear got %b exp 0",
               bus.illegal_o);
    end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_flow();
    test_load_use();
    test_freeze_flush();
    test_saturation();
    test_illegal();
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end
endmodule

// File: doc/control_pipe.md
Name: control_pipe

Overview:
- Receiving end of the main control decoder's 32-bit control word.
- Stages the word's datapath-relevant bits, plus the destination register number, through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Presents per-stage control signals to EX, MEM and WB.
- Handles load-use bubbles, branch/jump flushes and whole-pipe freezes, and reports inserted bubbles and illegal control words.

Parameters:
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous reset, active-low
- ctrl_i  in  32  control word from decoder: [0] RegWrite, [1] MemToReg, [2] MemWrite, [3] MemRead, [4] RegDst, [6:5] ALUOp, [7] ALUSrc, [8] Branch, [9] Jump, [31:10] reserved (zero)
- wr_reg_i  in  5  destination register number resolved in ID
- hazard_i  in  1  load-use stall from hazard unit; insert bubble into ID/EX
- flush_i  in  1  branch taken / jump; squash instruction entering ID/EX
- freeze_i  in  1  memory stall; hold all three stages
- ex_regdst_o  out  1  ID/EX RegDst
- ex_aluop_o  out  2  ID/EX ALUOp
- ex_alusrc_o  out  1  ID/EX ALUSrc
- ex_memread_o  out  1  ID/EX MemRead (to hazard unit)
- ex_wr_reg_o  out  5  ID/EX destination register
- mem_memread_o  out  1  EX/MEM MemRead
- mem_memwrite_o  out  1  EX/MEM MemWrite
- mem_regwrite_o  out  1  EX/MEM RegWrite (forwarding)
- mem_wr_reg_o  out  5  EX/MEM destination register
- wb_regwrite_o  out  1  MEM/WB RegWrite
- wb_memtoreg_o  out  1  MEM/WB MemToReg
- wb_wr_reg_o  out  5  MEM/WB destination register
- bubble_cnt_o  out  CNT_W  count of bubbles inserted
- illegal_o  out  1  sticky: nonzero reserved bits accepted

Behaviour:
- Stage contents:
  - Each stage holds ctrl[7:0] and a 5-bit register number.
  - ctrl[9:8] are not staged; Branch and Jump are consumed in ID by other logic.
- Reset (rst_i=0 at edge): all stage registers, all outputs, bubble_cnt_o and illegal_o go to 0. Reset overrides every other input, including mid-freeze.
- Priority per edge, rst_i=1:
  - freeze_i=1: all stages hold, the counter holds, and illegal_o does not set. A concurrent flush_i or hazard_i is ignored; the requester must keep it asserted until freeze_i drops.
  - else: MEM/WB <= EX/MEM and EX/MEM <= ID/EX.
    - If flush_i or hazard_i, ID/EX <= 0 (bubble: ctrl 8'h00, reg 0).
    - Otherwise ID/EX <= {ctrl_i[7:0], wr_reg_i}.
- Bubble counter:
  - Increments by 1 on each non-frozen edge that inserts a bubble. flush_i and hazard_i together count once.
  - Saturates at all-ones; no wrap.
- illegal_o sets on a non-frozen, non-bubble edge where ctrl_i[31:10] != 0. It is cleared only by reset.
- Output timing:
  - All outputs are registered, with no combinational path from any input.
  - An instruction's control reaches EX outputs 1 cycle after capture, MEM outputs after 2 and WB outputs after 3, plus 1 per frozen edge.
- An all-zero ctrl_i (decoder default/unknown opcode) propagates as a NOP; this is not illegal.

Test Plan:
- Reset: drive lw word 0x0000_00AB with rst_i=0 for 2 cycles -> all outputs 0; after release, ex_alusrc_o=1 and ex_memread_o=1 one cycle later.
- Pipeline flow: R-type 0x0000_0051 (wr_reg 3), then lw 0x0000_00AB (wr_reg 5) -> cycle 3 wb_regwrite_o=1, wb_memtoreg_o=0, wb_wr_reg_o=3; cycle 4 wb_memtoreg_o=1, wb_wr_reg_o=5.
- Load-use: lw then hazard_i=1 for one cycle -> ID/EX bubble (ex_* all 0), bubble_cnt_o=1; the bubble reaches WB with wb_regwrite_o=0.
- Freeze plus flush: freeze_i=1 and flush_i=1 for 3 cycles -> all outputs unchanged, bubble_cnt_o unchanged; on the first unfrozen edge with flush_i=1, bubble inserted and count +1.
- Saturation: CNT_W=4, 20 consecutive flushes -> bubble_cnt_o stops at 4'hF.
- Illegal: ctrl_i=0x0000_0401 while not frozen or bubbled -> illegal_o=1 and stays 1; the same word under hazard_i=1 -> illegal_o stays 0.
